// File: rtl/mem_responder.sv
// Memory-side responder: byte-wide RAM window at BASE with programmable read and
// write wait states, a registered read-data output enable, a ready handshake and a
// bus-error pulse for out-of-window or conflicting accesses.
module mem_responder #(
    parameter logic [15:0] BASE       = 16'h0000,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned RD_WAIT    = 1,
    parameter int unsigned WR_WAIT    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        mem_cs,
    input  logic        mem_oe,
    input  logic        mem_we,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        mem_rdy,
    output logic        bus_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_WAIT  = 3'd1;
    localparam logic [2:0] S_RD_DRIVE = 3'd2;
    localparam logic [2:0] S_WR_WAIT  = 3'd3;
    localparam logic [2:0] S_WR_DONE  = 3'd4;

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    localparam logic [3:0]  RD_CNT  = 4'(RD_WAIT);
    localparam logic [3:0]  WR_CNT  = 4'(WR_WAIT);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    // Set while an oe&we conflict has already been reported, so it pulses only once.
    logic        conflict_q, conflict_d;
    logic [7:0]  data_out_d;
    logic        data_oe_d, mem_rdy_d, bus_err_d;

    logic [7:0]  ram [DEPTH];
    logic        ram_we;
    logic [15:0] off;
    logic        in_win;
    logic [7:0]  rd_byte;
    logic        rd_req, wr_req;

    assign off     = addr_q - BASE;
    assign in_win  = {1'b0, off} < DEPTH_W;
    assign rd_byte = in_win ? ram[off[DEPTH_LOG2-1:0]] : 8'hFF;
    assign rd_req  = mem_cs & mem_oe;
    assign wr_req  = mem_cs & mem_we;

    // Next-state and registered-output decode for the access FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        conflict_d = 1'b0;
        data_out_d = data_out;
        data_oe_d  = 1'b0;
        mem_rdy_d  = 1'b0;
        bus_err_d  = 1'b0;
        ram_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_cs & mem_oe & mem_we) begin
                    conflict_d = 1'b1;
                    bus_err_d  = ~conflict_q;
                end else if (rd_req) begin
                    addr_d  = addr;
                    cnt_d   = RD_CNT;
                    state_d = S_RD_WAIT;
                end else if (wr_req) begin
                    addr_d  = addr;
                    wdata_d = data_in;
                    cnt_d   = WR_CNT;
                    state_d = S_WR_WAIT;
                end
            end

            S_RD_WAIT: begin
                if (!rd_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d    = S_RD_DRIVE;
                    data_out_d = rd_byte;
                    data_oe_d  = 1'b1;
                    mem_rdy_d  = 1'b1;
                    bus_err_d  = ~in_win;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_RD_DRIVE: begin
                if (!rd_req) begin
                    state_d = S_IDLE;
                end else if (addr != addr_q) begin
                    // New address mid-read: withdraw data and rerun the read latency.
                    addr_d  = addr;
                    cnt_d   = RD_CNT;
                    state_d = S_RD_WAIT;
                end else begin
                    data_oe_d = 1'b1;
                    mem_rdy_d = 1'b1;
                end
            end

            S_WR_WAIT: begin
                if (!wr_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    ram_we    = in_win;
                    bus_err_d = ~in_win;
                    mem_rdy_d = 1'b1;
                    state_d   = S_WR_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_WR_DONE: begin
                // Hold here so one long strobe commits exactly once.
                if (!wr_req) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, latched access and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 16'h0000;
            wdata_q    <= 8'h00;
            conflict_q <= 1'b0;
            data_out   <= 8'h00;
            data_oe    <= 1'b0;
            mem_rdy    <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            conflict_q <= conflict_d;
            data_out   <= data_out_d;
            data_oe    <= data_oe_d;
            mem_rdy    <= mem_rdy_d;
            bus_err    <= bus_err_d;
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[off[DEPTH_LOG2-1:0]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: drivers push expected responses
// (kind, data, error flag, cycle) and a monitor pops them as the DUT responds.
module tb_mem_responder;

    localparam logic [15:0] BASE_A = 16'h0000;
    localparam int          DLOG   = 8;
    localparam int          RD_W   = 1;
    localparam int          WR_W   = 2;

    localparam int K_RD = 0;
    localparam int K_WR = 1;
    localparam int K_ER = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        mem_cs, mem_oe, mem_we;
    logic [7:0]  data_out;
    logic        data_oe, mem_rdy, bus_err;

    int   cyc;
    int   checks;
    int   errors;
    logic prev_oe;
    exp_t exp_q[$];
    logic [7:0] ref_mem [1 << DLOG];

    mem_responder #(
        .BASE       (BASE_A),
        .DEPTH_LOG2 (DLOG),
        .RD_WAIT    (RD_W),
        .WR_WAIT    (WR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .mem_cs   (mem_cs),
        .mem_oe   (mem_oe),
        .mem_we   (mem_we),
        .data_out (data_out),
        .data_oe  (data_oe),
        .mem_rdy  (mem_rdy),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic in_win(input logic [15:0] a);
        logic [15:0] o;
        o = a - BASE_A;
        return int'(o) < (1 << DLOG);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        logic [15:0] o;
        o = a - BASE_A;
        return in_win(a) ? ref_mem[o[DLOG-1:0]] : 8'hFF;
    endfunction

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 16'(16'h0100 + $urandom_range(0, 16'hFEFF));
        return 16'($urandom_range(0, (1 << DLOG) - 1));
    endfunction

    task automatic push_exp(input int kind, input logic [7:0] d, input logic err, input int c);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.err  = err;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Pops an expectation for each response the DUT presents.
    task automatic monitor();
        exp_t e;
        int   kind;
        logic ev;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ev   = 1'b0;
                kind = K_ER;
                if (data_oe && !prev_oe) begin
                    ev = 1'b1; kind = K_RD;
                end else if (mem_rdy && !data_oe) begin
                    ev = 1'b1; kind = K_WR;
                end else if (bus_err && !data_oe) begin
                    ev = 1'b1; kind = K_ER;
                end
                if (data_oe && prev_oe) begin
                    checks++;
                    if (!mem_rdy || bus_err) begin
                        errors++;
                        $display("FAIL hold @%0d: rdy=%0b err=%0b while driving, expected rdy=1 err=0",
                                 cyc, mem_rdy, bus_err);
                    end
                end
                if (ev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected @%0d: kind=%0d data=%02h err=%0b, expected none",
                                 cyc, kind, data_out, bus_err);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != kind || e.cyc != cyc || e.err !== bus_err ||
                            (kind == K_RD && e.data !== data_out)) begin
                            errors++;
                            $display("FAIL sb_resp: got kind=%0d data=%02h err=%0b cyc=%0d, expected kind=%0d data=%02h err=%0b cyc=%0d",
                                     kind, data_out, bus_err, cyc, e.kind, e.data, e.err, e.cyc);
                        end
                    end
                end
            end
            prev_oe = data_oe;
        end
    endtask

    task automatic do_read(input logic [15:0] a, input int h);
        int c;
        @(negedge clk);
        c = cyc;
        mem_cs = 1'b1; mem_oe = 1'b1; mem_we = 1'b0; addr = a;
        if (h >= RD_W + 2) push_exp(K_RD, ref_rd(a), ~in_win(a), c + RD_W + 2);
        repeat (h) @(negedge clk);
        mem_cs = 1'b0; mem_oe = 1'b0;
        if (h >= RD_W + 2) begin
            @(negedge clk);
            check("oe_drop", {31'd0, data_oe}, 32'd0);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int h);
        int c;
        logic [15:0] o;
        @(negedge clk);
        c = cyc;
        mem_cs = 1'b1; mem_we = 1'b1; mem_oe = 1'b0; addr = a; data_in = d;
        if (h >= WR_W + 2) begin
            push_exp(K_WR, 8'h00, ~in_win(a), c + WR_W + 2);
            o = a - BASE_A;
            if (in_win(a)) ref_mem[o[DLOG-1:0]] = d;
        end
        @(negedge clk);
        data_in = ~d;  // write data must have been latched at the strobe
        repeat (h - 1) @(negedge clk);
        mem_cs = 1'b0; mem_we = 1'b0;
    endtask

    task automatic do_conflict(input logic [15:0] a, input int h, input logic follow);
        @(negedge clk);
        mem_cs = 1'b1; mem_oe = 1'b1; mem_we = 1'b1; addr = a;
        push_exp(K_ER, 8'h00, 1'b1, cyc + 1);
        repeat (h) @(negedge clk);
        if (follow) begin
            do_read(a, RD_W + 2 + int'($urandom_range(0, 2)));
        end else begin
            mem_cs = 1'b0; mem_oe = 1'b0; mem_we = 1'b0;
        end
    endtask

    task automatic do_read_change(input logic [15:0] a1, input logic [15:0] a2);
        @(negedge clk);
        mem_cs = 1'b1; mem_oe = 1'b1; mem_we = 1'b0; addr = a1;
        push_exp(K_RD, ref_rd(a1), ~in_win(a1), cyc + RD_W + 2);
        repeat (RD_W + 3) @(negedge clk);
        addr = a2;
        push_exp(K_RD, ref_rd(a2), ~in_win(a2), cyc + RD_W + 2);
        repeat (RD_W + 3) @(negedge clk);
        mem_cs = 1'b0; mem_oe = 1'b0;
    endtask

    // Reset asserted mid-access: outputs must clear at once, pending write is lost.
    task automatic do_reset_mid(input logic [15:0] a, input logic [7:0] d, input logic is_wr);
        @(negedge clk);
        mem_cs = 1'b1; addr = a;
        if (is_wr) begin
            mem_we = 1'b1; mem_oe = 1'b0; data_in = d;
            repeat (WR_W + 1) @(negedge clk);
        end else begin
            mem_oe = 1'b1; mem_we = 1'b0;
            push_exp(K_RD, ref_rd(a), ~in_win(a), cyc + RD_W + 2);
            repeat (RD_W + 3) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1 check(is_wr ? "rst_in_write" : "rst_in_read",
                 {20'd0, data_out, data_oe, mem_rdy, bus_err}, 32'd0);
        @(negedge clk);
        mem_cs = 1'b0; mem_oe = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; prev_oe = 1'b0;
        rst_n = 1'b0; addr = 16'h0000; data_in = 8'h00;
        mem_cs = 1'b0; mem_oe = 1'b0; mem_we = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        check("reset_data_oe", {31'd0, data_oe}, 32'd0);
        check("reset_mem_rdy", {31'd0, mem_rdy}, 32'd0);
        check("reset_bus_err", {31'd0, bus_err}, 32'd0);
        rst_n = 1'b1;

        // Fill the whole window so every later read has a known value.
        for (int i = 0; i < (1 << DLOG); i++)
            do_write(16'(i), 8'($urandom), WR_W + 2 + int'($urandom_range(0, 1)));

        // Directed scenarios
        do_write(16'h0010, 8'hA5, WR_W + 2);
        do_read(16'h0010, 5);
        do_write(16'h0020, 8'h3C, 6);
        do_read(16'h0020, 4);
        do_read(16'h0100, 4);
        do_write(16'h0100, 8'h77, 5);
        do_read(16'h0000, 4);
        do_conflict(16'h0030, 3, 1'b1);
        do_conflict(16'h0031, 1, 1'b0);
        do_write(16'h0011, 8'h5A, WR_W + 2);
        do_read_change(16'h0010, 16'h0011);
        do_write(16'h0040, 8'h11, WR_W + 2);
        do_reset_mid(16'h0040, 8'hEE, 1'b1);
        do_read(16'h0040, 4);
        do_reset_mid(16'h0041, 8'h00, 1'b0);
        do_read(16'h0042, 1);
        do_read(16'h0042, RD_W + 1);
        do_write(16'h0043, 8'h99, WR_W + 1);
        do_read(16'h0043, RD_W + 2);

        // Random mix
        for (int i = 0; i < 200; i++) begin
            int op;
            logic [15:0] a;
            op = int'($urandom_range(0, 9));
            a  = rand_addr();
            case (op)
                0, 1, 2: do_read(a, int'($urandom_range(1, 6)));
                3, 4, 5: do_write(a, 8'($urandom), int'($urandom_range(1, 6)));
                6:       do_conflict(a, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
                7:       do_read_change(a, a ^ 16'($urandom_range(1, 255)));
                default: do_read(a, RD_W + 2 + int'($urandom_range(0, 3)));
            endcase
        end

        repeat (10) @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
